// File: rtl/sort_seq_if.sv
// Handshake bundle for sort_seq: an unsorted vector goes in, the sorted vector comes out.
// slave is the sorter side, master is the producer/consumer side.
interface sort_seq_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LENGTH = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LENGTH + 1);
  localparam int unsigned BUS_W = MAX_LENGTH * DATA_WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic             in_dir;
  logic [LEN_W-1:0] in_len;
  logic [BUS_W-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out;
  logic             busy;

  modport slave (
    input  in_valid, in_dir, in_len, in, out_ready,
    output in_ready, out_valid, out, busy
  );

  modport master (
    output in_valid, in_dir, in_len, in, out_ready,
    input  in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/sort_seq.sv
// Iterative odd-even transposition sorter: one rank of MAX_LENGTH/2 comparators reused each pass.
// Optional SORT_EARLY_EXIT_EN: finish once two consecutive passes make no swaps.
module sort_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LENGTH = 16
) (
  input logic       clk,
  input logic       rst,
  sort_seq_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LENGTH + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LENGTH);
  localparam int unsigned NPAIR = MAX_LENGTH / 2;

  typedef logic [MAX_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;

  state_t            state_q, state_d;
  vec_t              arr_q, arr_d, out_q;
  logic              dir_q;
  logic [LEN_W-1:0]  len_q, len_clamp;
  logic [IDX_W-1:0]  pass_q;
  logic              in_ready_q, out_valid_q, busy_q;
  logic              pass_end;
  logic [IDX_W-1:0]  lo_idx, hi_idx;
  int unsigned       lo_pos;
  logic [DATA_WIDTH-1:0] a_el, b_el;
`ifdef SORT_EARLY_EXIT_EN
  logic              swapped;
  logic              clean_q;
`endif

  assign len_clamp = (bus.in_len > LEN_W'(MAX_LENGTH)) ? LEN_W'(MAX_LENGTH) : bus.in_len;

  // One pass: comparator k sees pair (2k+odd, 2k+odd+1); pairs reaching past len are idle.
  always_comb begin
    arr_d  = arr_q;
    lo_pos = 0;
    lo_idx = '0;
    hi_idx = '0;
    a_el   = '0;
    b_el   = '0;
`ifdef SORT_EARLY_EXIT_EN
    swapped = 1'b0;
`endif
    for (int unsigned k = 0; k < NPAIR; k++) begin
      lo_pos = 2 * k + 32'(pass_q[0]);
      if (lo_pos + 1 < MAX_LENGTH) begin
        lo_idx = IDX_W'(lo_pos);
        hi_idx = IDX_W'(lo_pos + 1);
        a_el   = arr_q[lo_idx];
        b_el   = arr_q[hi_idx];
        if ((LEN_W'(lo_pos + 1) < len_q) && (dir_q ? (a_el > b_el) : (a_el < b_el))) begin
          arr_d[lo_idx] = b_el;
          arr_d[hi_idx] = a_el;
`ifdef SORT_EARLY_EXIT_EN
          swapped = 1'b1;
`endif
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pass_end = (pass_q == IDX_W'(MAX_LENGTH - 1));
`ifdef SORT_EARLY_EXIT_EN
    if ((pass_q != '0) && !swapped && clean_q) pass_end = 1'b1;
`endif
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_SORT;
      S_SORT:  if (pass_end)      state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_q       <= '0;
      out_q       <= '0;
      dir_q       <= 1'b0;
      len_q       <= '0;
      pass_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      clean_q     <= 1'b0;
`endif
    end else begin
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_SORT);
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            arr_q  <= bus.in;
            dir_q  <= bus.in_dir;
            len_q  <= len_clamp;
            pass_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
            clean_q <= 1'b0;
`endif
          end
        end
        S_SORT: begin
          arr_q  <= arr_d;
          pass_q <= pass_q + IDX_W'(1);
`ifdef SORT_EARLY_EXIT_EN
          clean_q <= !swapped;
`endif
          if (pass_end) out_q <= arr_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sort_seq.sv
// Self-checking bench for sort_seq (DATA_WIDTH=8, MAX_LENGTH=8): table vectors, corner sequences,
// and random vectors against a plain insertion-sort reference.
module tb_sort_seq;
  localparam int unsigned DW = 8;
  localparam int unsigned ML = 8;
  localparam int unsigned LW = $clog2(ML + 1);
  localparam int unsigned BW = DW * ML;

  typedef logic [BW-1:0] vec_t;
  typedef struct {
    vec_t          data;
    logic          dir;
    logic [LW-1:0] len;
    vec_t          exp;
    int            ee_lat;
  } rec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sort_seq_if #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) bus ();
  sort_seq #(.DATA_WIDTH(DW), .MAX_LENGTH(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input vec_t got, input vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Reference: stable insertion sort of the first min(len, ML) elements, the rest untouched.
  function automatic vec_t ref_sort(input vec_t d, input logic dir, input logic [LW-1:0] len);
    logic [DW-1:0] e [ML];
    logic [DW-1:0] key;
    int   n, j, mlen;
    vec_t r;
    mlen = ML;
    n = (int'(len) > mlen) ? mlen : int'(len);
    for (int i = 0; i < mlen; i++) e[i] = d[i*DW +: DW];
    for (int i = 1; i < n; i++) begin
      key = e[i];
      j = i;
      while (j > 0 && (dir ? (e[j-1] > key) : (e[j-1] < key))) begin
        e[j] = e[j-1];
        j--;
      end
      e[j] = key;
    end
    r = '0;
    for (int i = 0; i < mlen; i++) r[i*DW +: DW] = e[i];
    return r;
  endfunction

  task automatic send(input vec_t d, input logic dir, input logic [LW-1:0] len);
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin cycle(); t++; end
    chk("in_ready_wait", BW'(bus.in_ready), BW'(1));
    bus.in       = d;
    bus.in_dir   = dir;
    bus.in_len   = len;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk("busy_after_accept", BW'(bus.busy), BW'(1));
    chk("in_ready_after_accept", BW'(bus.in_ready), BW'(0));
  endtask

  // Called right after the accept edge: measures latency, checks data, holds, then handshakes.
  task automatic collect(input string name, input vec_t exp, input int ee_lat, input int hold);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin cycle(); lat++; end
`ifdef SORT_EARLY_EXIT_EN
    if (ee_lat > 0) chk({name, "_lat"}, BW'(lat), BW'(ee_lat));
    else            chk({name, "_lat_range"}, BW'(lat >= 2 && lat <= int'(ML)), BW'(1));
`else
    chk({name, "_lat"}, BW'(lat), BW'(ML));
    if (ee_lat < 0) chk({name, "_unused"}, BW'(ee_lat), BW'(0));
`endif
    chk({name, "_out"}, bus.out, exp);
    for (int h = 0; h < hold; h++) begin
      cycle();
      chk({name, "_hold_valid"}, BW'(bus.out_valid), BW'(1));
      chk({name, "_hold_out"}, bus.out, exp);
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk({name, "_valid_drop"}, BW'(bus.out_valid), BW'(0));
    chk({name, "_ready_back"}, BW'(bus.in_ready), BW'(1));
    chk({name, "_out_kept"}, bus.out, exp);
  endtask

  initial begin
    rec_t tbl [7];
    vec_t va, vb, ea, eb, d, e;
    logic dir;
    logic [LW-1:0] len;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_dir    = 1'b0;
    bus.in_len    = '0;
    bus.in        = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{data: pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), dir: 1'b0, len: LW'(8),
               exp:  pk(8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01), ee_lat: 0};
    tbl[1] = '{data: pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), dir: 1'b1, len: LW'(8),
               exp:  pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), ee_lat: 2};
    tbl[2] = '{data: pk(8'h03,8'h09,8'h01,8'h07,8'hAA,8'hBB,8'hCC,8'hDD), dir: 1'b0, len: LW'(4),
               exp:  pk(8'h09,8'h07,8'h03,8'h01,8'hAA,8'hBB,8'hCC,8'hDD), ee_lat: 0};
    tbl[3] = '{data: pk(8'hFF,8'h00,8'hFF,8'h00,8'h80,8'h80,8'h00,8'hFF), dir: 1'b1, len: LW'(15),
               exp:  pk(8'h00,8'h00,8'h00,8'h80,8'h80,8'hFF,8'hFF,8'hFF), ee_lat: 0};
    tbl[4] = '{data: pk(8'h05,8'h03,8'h09,8'h01,8'h02,8'h07,8'h06,8'h04), dir: 1'b0, len: LW'(1),
               exp:  pk(8'h05,8'h03,8'h09,8'h01,8'h02,8'h07,8'h06,8'h04), ee_lat: 2};
    tbl[5] = '{data: pk(8'h09,8'h03,8'h07,8'h01,8'h02,8'h08,8'h06,8'h04), dir: 1'b1, len: LW'(2),
               exp:  pk(8'h03,8'h09,8'h07,8'h01,8'h02,8'h08,8'h06,8'h04), ee_lat: 3};
    tbl[6] = '{data: pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), dir: 1'b0, len: LW'(0),
               exp:  pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08), ee_lat: 2};

    // Reset state
    cycle();
    cycle();
    chk("rst_in_ready", BW'(bus.in_ready), BW'(1));
    chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
    chk("rst_out", bus.out, '0);
    chk("rst_busy", BW'(bus.busy), BW'(0));
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].data, tbl[i].dir, tbl[i].len);
      collect($sformatf("vec%0d", i), tbl[i].exp, tbl[i].ee_lat, 0);
    end

    // Backpressure with a second vector pending the whole time
    va = pk(8'h10,8'h40,8'h20,8'h30,8'h70,8'h50,8'h60,8'h00);
    ea = pk(8'h70,8'h60,8'h50,8'h40,8'h30,8'h20,8'h10,8'h00);
    vb = pk(8'h05,8'h01,8'h04,8'h02,8'h03,8'h08,8'h07,8'h06);
    eb = pk(8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08);
    send(va, 1'b0, LW'(8));
    bus.in = vb; bus.in_dir = 1'b1; bus.in_len = LW'(8); bus.in_valid = 1'b1;
    begin
      int t;
      t = 0;
      while (!bus.out_valid && t < 100) begin
        cycle(); t++;
        if (!bus.out_valid) chk("bp_sort_in_ready", BW'(bus.in_ready), BW'(0));
      end
`ifndef SORT_EARLY_EXIT_EN
      chk("bp_lat", BW'(t), BW'(ML));
`endif
    end
    chk("bp_out", bus.out, ea);
    for (int h = 0; h < 5; h++) begin
      cycle();
      chk("bp_hold_out", bus.out, ea);
      chk("bp_hold_in_ready", BW'(bus.in_ready), BW'(0));
      chk("bp_hold_valid", BW'(bus.out_valid), BW'(1));
    end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", BW'(bus.in_ready), BW'(1));
    chk("bp_release_valid", BW'(bus.out_valid), BW'(0));
    cycle();
    bus.in_valid = 1'b0;
    chk("bp_second_accept", BW'(bus.busy), BW'(1));
    collect("bp_second", eb, 0, 0);

    // Reset three cycles into SORT
    send(va, 1'b1, LW'(8));
    cycle(); cycle(); cycle();
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", BW'(bus.out_valid), BW'(0));
    chk("rstmid_out", bus.out, '0);
    chk("rstmid_in_ready", BW'(bus.in_ready), BW'(1));
    chk("rstmid_busy", BW'(bus.busy), BW'(0));
    cycle();
    rst = 1'b0;
    cycle();
    send(vb, 1'b0, LW'(8));
    collect("rstmid_fresh", pk(8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01), 0, 1);

    // Random vectors against the reference
    for (int it = 0; it < 40; it++) begin
      d = '0;
      for (int b = 0; b < int'(ML); b++)
        d[b*DW +: DW] = (it % 2 == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
      dir = 1'($urandom_range(0, 1));
      len = LW'($urandom_range(0, 15));
      e = ref_sort(d, dir, len);
      send(d, dir, len);
      collect($sformatf("rand%0d", it), e, 0, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
